// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and parity helper.
// Used by the RX engine and reusable by the TX parity generator.
`timescale 1ns/1ps
package uart_pkg;

    localparam int OSR_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Parity bit that should accompany a right-aligned character.
    // {sticky,eps}: 00 odd, 01 even, 10 forced 1, 11 forced 0.
    function automatic logic exp_parity(
        input logic [7:0] data,
        input logic [1:0] wls,
        input logic       sticky,
        input logic       eps
    );
        logic [7:0] d;
        logic       p;
        d = data & (8'hFF >> (2'd3 - wls));
        unique case ({sticky, eps})
            2'b00:   p = ~^d;
            2'b01:   p = ^d;
            2'b10:   p = 1'b1;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: STAGES-deep synchroniser for the async rx line.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
`timescale 1ns/1ps
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_top.sv
// uart_rx_top: 16550 receive engine; oversamples rx, frames one
// character per LCR settings and pushes it with pe/fe/bi to the RX FIFO.
// Ports: clk, rst, baud_pulse, rx, pen, eps, sticky_parity, wls[1:0] in;
//        push, dout[7:0], pe, fe, bi, rx_busy out.
`timescale 1ns/1ps
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int OSR         = OSR_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_parity,
    input  logic [1:0] wls,
    output logic       push,
    output logic [7:0] dout,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic       rx_busy
);

    localparam int CW = $clog2(OSR);
    localparam logic [CW-1:0] HALF = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(OSR - 1);

    logic rx_s;

    uart_rx_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    rx_state_t     state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          perr_q, perr_d;
    logic          psamp_q, psamp_d;
    logic          armed_q, armed_d;
    logic          push_q, push_d;
    logic [7:0]    dout_q, dout_d;
    logic          pe_q, pe_d;
    logic          fe_q, fe_d;
    logic          bi_q, bi_d;
    logic [7:0]    shift_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            perr_q   <= 1'b0;
            psamp_q  <= 1'b0;
            armed_q  <= 1'b1;
            push_q   <= 1'b0;
            dout_q   <= '0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            bi_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            perr_q   <= perr_d;
            psamp_q  <= psamp_d;
            armed_q  <= armed_d;
            push_q   <= push_d;
            dout_q   <= dout_d;
            pe_q     <= pe_d;
            fe_q     <= fe_d;
            bi_q     <= bi_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        perr_d   = perr_q;
        psamp_d  = psamp_q;
        armed_d  = armed_q;
        push_d   = 1'b0;
        dout_d   = dout_q;
        pe_d     = pe_q;
        fe_d     = fe_q;
        bi_d     = bi_q;
        shift_nx = {rx_s, shift_q[7:1]};

        if (baud_pulse) begin
            unique case (state_q)
                IDLE: begin
                    // After a low stop bit, wait for the line to go
                    // high before hunting for the next start edge.
                    if (!armed_q) begin
                        if (rx_s) armed_d = 1'b1;
                    end else if (!rx_s) begin
                        state_d = START;
                        count_d = HALF;
                    end
                end
                START: begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DATA;
                        count_d  = FULL;
                        bitcnt_d = {1'b1, wls};
                    end
                end
                DATA: begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else begin
                        shift_d = shift_nx;
                        count_d = FULL;
                        if (bitcnt_q != '0) begin
                            bitcnt_d = bitcnt_q - 1'b1;
                        end else begin
                            // Short words sit in the top bits; drop
                            // the stale low bits and right-align.
                            data_d  = shift_nx >> (2'd3 - wls);
                            state_d = pen ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else begin
                        psamp_d = rx_s;
                        perr_d  = rx_s != exp_parity(data_q, wls,
                                                     sticky_parity, eps);
                        state_d = STOP;
                        count_d = FULL;
                    end
                end
                STOP: begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else begin
                        push_d  = 1'b1;
                        dout_d  = data_q;
                        pe_d    = perr_q & pen;
                        fe_d    = ~rx_s;
                        bi_d    = ~rx_s & (data_q == 8'h00)
                                  & (~pen | ~psamp_q);
                        state_d = IDLE;
                        if (!rx_s) armed_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign push    = push_q;
    assign dout    = dout_q;
    assign pe      = pe_q;
    assign fe      = fe_q;
    assign bi      = bi_q;
    assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: scenario tasks plus randomized frames checked against
// a bit-level model of the serial character format.
`timescale 1ns/1ps
module tb_uart_rx_top;

    localparam int BIT = 96;  // 16 ticks x 6 clk per tick

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_pulse = 1'b0;
    logic       rx = 1'b1;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sticky_parity = 1'b0;
    logic [1:0] wls = 2'b11;
    logic       push;
    logic [7:0] dout;
    logic       pe;
    logic       fe;
    logic       bi;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;
    int bcnt = 0;
    logic [10:0] rxq[$];  // {dout, pe, fe, bi}

    always #5 clk = ~clk;

    uart_rx_top dut (
        .clk          (clk),
        .rst          (rst),
        .baud_pulse   (baud_pulse),
        .rx           (rx),
        .pen          (pen),
        .eps          (eps),
        .sticky_parity(sticky_parity),
        .wls          (wls),
        .push         (push),
        .dout         (dout),
        .pe           (pe),
        .fe           (fe),
        .bi           (bi),
        .rx_busy      (rx_busy)
    );

    initial begin
        forever begin
            @(negedge clk);
            bcnt++;
            baud_pulse = (bcnt % 6 == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (push === 1'b1) rxq.push_back({dout, pe, fe, bi});
        end
    end

    // Parity bit a correct transmitter would send for n data bits.
    function automatic logic par_bit(input logic [7:0] d, input int n,
                                     input logic even, input logic stick);
        int ones;
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(d[i]);
        if (stick) return !even;
        if (even) return (ones % 2) == 1;
        return (ones % 2) == 0;
    endfunction

    function automatic logic [10:0] model(
        input logic [7:0] d, input logic [1:0] wl, input logic p,
        input logic e, input logic s, input logic flip, input logic stopb);
        int n;
        logic [7:0] dm;
        logic sp, x_pe, x_fe, x_bi;
        n = 5 + int'(wl);
        dm = 8'h00;
        for (int i = 0; i < n; i++) dm[i] = d[i];
        sp = par_bit(dm, n, e, s) ^ flip;
        x_pe = p & flip;
        x_fe = !stopb;
        x_bi = !stopb && (dm == 8'h00) && (!p || !sp);
        return {dm, x_pe, x_fe, x_bi};
    endfunction

    task automatic drive(input logic b, input int clks);
        rx = b;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(
        input logic [7:0] d, input logic [1:0] wl, input logic p,
        input logic e, input logic s, input logic flip, input logic stopb,
        input int idle);
        int n;
        @(negedge clk);
        wls = wl;
        pen = p;
        eps = e;
        sticky_parity = s;
        n = 5 + int'(wl);
        drive(1'b0, BIT);
        for (int i = 0; i < n; i++) drive(d[i], BIT);
        if (p) drive(par_bit(d, n, e, s) ^ flip, BIT);
        drive(stopb, BIT);
        drive(1'b1, idle * BIT);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({push, rx_busy, dout, pe, fe, bi} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0",
                     {push, rx_busy, dout, pe, fe, bi});
        end
        rst = 1'b0;
        rxq.delete();
        drive(1'b1, 2 * BIT);
        checks++;
        if (rx_busy !== 1'b0 || rxq.size() != 0) begin
            errors++;
            $display("FAIL reset_idle busy=%b pushes=%0d want 0/0",
                     rx_busy, rxq.size());
        end
    endtask

    task automatic test_loopback();
        rxq.delete();
        send_frame(8'h13, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        checks++;
        if (rxq.size() != 1) begin
            errors++;
            $display("FAIL loopback_count got=%0d want=1", rxq.size());
        end else begin
            checks++;
            if (rxq[0] !== {8'h13, 3'b000}) begin
                errors++;
                $display("FAIL loopback_data got=%h want=%h",
                         rxq[0], {8'h13, 3'b000});
            end
        end
    endtask

    task automatic test_parity_error();
        rxq.delete();
        send_frame(8'h13, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        checks++;
        if (rxq.size() != 1) begin
            errors++;
            $display("FAIL parity_count got=%0d want=1", rxq.size());
        end else begin
            checks++;
            if (rxq[0] !== {8'h13, 3'b100}) begin
                errors++;
                $display("FAIL parity_err got=%h want=%h",
                         rxq[0], {8'h13, 3'b100});
            end
        end
    endtask

    task automatic test_short_words();
        rxq.delete();
        send_frame(8'h16, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        send_frame(8'h55, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        checks++;
        if (rxq.size() != 2) begin
            errors++;
            $display("FAIL short_count got=%0d want=2", rxq.size());
        end else begin
            checks++;
            if (rxq[0] !== {8'h16, 3'b000}) begin
                errors++;
                $display("FAIL short_5bit got=%h want=%h",
                         rxq[0], {8'h16, 3'b000});
            end
            checks++;
            if (rxq[1] !== {8'h55, 3'b000}) begin
                errors++;
                $display("FAIL short_7bit got=%h want=%h",
                         rxq[1], {8'h55, 3'b000});
            end
        end
    endtask

    task automatic test_glitch_framing();
        rxq.delete();
        drive(1'b0, 4 * 6);
        drive(1'b1, BIT);
        checks++;
        if (rx_busy !== 1'b0 || rxq.size() != 0) begin
            errors++;
            $display("FAIL glitch busy=%b pushes=%0d want 0/0",
                     rx_busy, rxq.size());
        end
        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        checks++;
        if (rxq.size() != 1) begin
            errors++;
            $display("FAIL framing_count got=%0d want=1", rxq.size());
        end else begin
            checks++;
            if (rxq[0] !== {8'hA5, 3'b010}) begin
                errors++;
                $display("FAIL framing_err got=%h want=%h",
                         rxq[0], {8'hA5, 3'b010});
            end
        end
    endtask

    task automatic test_break();
        @(negedge clk);
        wls = 2'b11;
        pen = 1'b0;
        rxq.delete();
        drive(1'b0, 3 * 10 * BIT);
        checks++;
        if (rxq.size() != 1) begin
            errors++;
            $display("FAIL break_count got=%0d want=1", rxq.size());
        end else begin
            checks++;
            if (rxq[0] !== {8'h00, 3'b011}) begin
                errors++;
                $display("FAIL break_flags got=%h want=%h",
                         rxq[0], {8'h00, 3'b011});
            end
        end
        drive(1'b1, 2 * BIT);
        checks++;
        if (rxq.size() != 1 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL break_rearm pushes=%0d busy=%b want 1/0",
                     rxq.size(), rx_busy);
        end
        rxq.delete();
        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        checks++;
        if (rxq.size() != 1 || rxq[0] !== {8'h3C, 3'b000}) begin
            errors++;
            $display("FAIL break_after n=%0d got=%h want=%h", rxq.size(),
                     rxq.size() != 0 ? rxq[0] : 11'h0, {8'h3C, 3'b000});
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        wls = 2'b11;
        pen = 1'b0;
        rxq.delete();
        drive(1'b0, BIT);
        drive(1'b1, 4 * BIT + BIT / 2);
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before got=%b want=1", rx_busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (rx_busy !== 1'b0 || push !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort busy=%b push=%b want 0/0",
                     rx_busy, push);
        end
        drive(1'b1, 6 * BIT);
        checks++;
        if (rxq.size() != 0) begin
            errors++;
            $display("FAIL midrst_nopush got=%0d want=0", rxq.size());
        end
        send_frame(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        checks++;
        if (rxq.size() != 1 || rxq[0] !== {8'hFF, 3'b000}) begin
            errors++;
            $display("FAIL midrst_after n=%0d got=%h want=%h", rxq.size(),
                     rxq.size() != 0 ? rxq[0] : 11'h0, {8'hFF, 3'b000});
        end
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic [1:0]  wl;
        logic        p, e, s, flip, stopb;
        logic [10:0] exp;
        for (int k = 0; k < 16; k++) begin
            d     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            wl    = 2'($urandom_range(0, 3));
            p     = 1'($urandom);
            e     = 1'($urandom);
            s     = 1'($urandom);
            flip  = p && ($urandom_range(0, 2) == 0);
            stopb = ($urandom_range(0, 4) != 0);
            exp   = model(d, wl, p, e, s, flip, stopb);
            rxq.delete();
            send_frame(d, wl, p, e, s, flip, stopb, 2);
            checks++;
            if (rxq.size() != 1) begin
                errors++;
                $display("FAIL rand%0d_count got=%0d want=1",
                         k, rxq.size());
            end else begin
                checks++;
                if (rxq[0] !== exp) begin
                    errors++;
                    $display("FAIL rand%0d_char got=%h want=%h",
                             k, rxq[0], exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_parity_error();
        test_short_words();
        test_glitch_framing();
        test_break();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
